// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, field and fetch-state definitions for the 16-bit CPU
//
// Purpose: single source for instruction field positions, opcode constants
// and the fetch FSM state encoding used by the fetch stage.
// Ports: none (package).
package cpu_pkg;

  // Opcodes the fetch stage or its neighbours care about
  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1101;
  localparam logic [3:0] OP_BNE  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Instruction field bit positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int JT_MSB = 11;  // jump target is instr[JT_MSB:0]
  localparam int BR_MSB = 7;   // branch offset is instr[BR_MSB:0], signed

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - combinational next-PC select for the fetch stage
//
// Purpose: picks jump target, branch target or sequential PC.
// Ports:
//   pc      in  PC_W : address of the instruction being issued
//   instr   in  16   : instruction being issued
//   jump    in  1    : take jump target (wins over branch)
//   branch  in  1    : take pc + 1 + sign-extended offset
//   pc_next out PC_W : selected next fetch address (modulo 2^PC_W)
module fetch_pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  input  logic            jump,
  input  logic            branch,
  output logic [PC_W-1:0] pc_next
);

  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_jmp_tgt;
  logic [PC_W-1:0] w_br_off;
  logic [PC_W-1:0] w_br_tgt;
  logic            w_unused;

  // Opcode bits are decoded elsewhere; only target/offset fields matter here
  assign w_unused = &{1'b0, instr[OP_MSB:OP_LSB]};

  // Casts give zero-extension/truncation for the jump target and
  // sign-extension for the branch offset; sums wrap at PC_W bits.
  assign w_seq     = pc + PC_W'(1);
  assign w_jmp_tgt = PC_W'(instr[JT_MSB:0]);
  assign w_br_off  = PC_W'($signed(instr[BR_MSB:0]));
  assign w_br_tgt  = w_seq + w_br_off;

  always_comb begin
    pc_next = w_seq;
    if (jump) begin
      pc_next = w_jmp_tgt;
    end else if (branch) begin
      pc_next = w_br_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IR and request/ack FSM
//
// Purpose: fetches one instruction per imem handshake, holds it in the
// instruction register while issued to ctrlunit, then steps the PC using
// ctrlunit's jump/branch decision.
// Ports:
//   clk, rst          in  : clock, synchronous active-high reset
//   imem_req/addr     out : fetch request and word address (= pc)
//   imem_ack/data     in  : memory response
//   stall             in  : hold the issued instruction
//   jump, branch      in  : redirect decisions from ctrlunit
//   OP, instr         out : opcode and instruction register
//   pc                out : address of instr
//   instr_valid       out : instr/OP are live
//   halted            out : HALT was issued
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               jump,
  input  logic               branch,
  output logic [3:0]         OP,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic               halted
);

  fetch_state_t       r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_req;
  logic               r_valid;
  logic               r_halted;

  logic [PC_W-1:0]    w_pc_next;
  logic [3:0]         w_op;

  assign w_op = r_instr[OP_MSB:OP_LSB];

  fetch_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc      (r_pc),
    .instr   (r_instr),
    .jump    (jump),
    .branch  (branch),
    .pc_next (w_pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_REQ;
      r_pc     <= '0;
      r_instr  <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_REQ: begin
          // First REQ cycle after reset has req low; any ack then is stray
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem_ack) begin
            r_instr <= imem_data;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            r_valid <= 1'b0;
            if (w_op == OP_HALT) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              // Raise req together with the new PC so a redirect is fetched
              // on the very next cycle without a dead REQ cycle.
              r_pc    <= w_pc_next;
              r_req   <= 1'b1;
              r_state <= ST_REQ;
            end
          end
        end
        ST_HALT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_REQ;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign OP          = w_op;
  assign instr       = r_instr;
  assign pc          = r_pc;
  assign instr_valid = r_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall;
  logic        jump;
  logic        branch;
  logic [3:0]  OP;
  logic [15:0] instr;
  logic [11:0] pc;
  logic        instr_valid;
  logic        halted;

  logic        ack_en;
  logic        ack_force;
  logic [15:0] mem [0:4095];

  int total;
  int bad;

  fetch_unit #(
    .PC_W    (12),
    .INSTR_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .OP          (OP),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack  = (ack_en & imem_req) | ack_force;
  assign imem_data = mem[imem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 16'h2000 + 16'(a);
    mem[5]  = {OP_JMP, 12'h123};
    mem[12'h123] = {OP_JMP, 12'h00A};
    mem[10] = {OP_BEQ, 4'h0, 8'hFE};
    mem[9]  = {OP_JMP, 12'h00A};
    mem[12] = {OP_JMP, 12'hFFF};
    rst = 1'b1; ack_en = 1'b1; ack_force = 1'b0;
    stall = 1'b0; jump = 1'b0; branch = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);

    // Sequential fetch with zero-latency memory
    rst = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("seq_req", imem_req, 1);
      chk("seq_addr", imem_addr, i);
      chk("seq_valid_lo", instr_valid, 0);
      step();
      chk("seq_valid_hi", instr_valid, 1);
      chk("seq_pc", pc, i);
      chk("seq_instr", instr, 32'h2000 + i);
      chk("seq_req_lo", imem_req, 0);
      step();
    end

    // Jump at pc 5 -> 0x123, address 6 never requested
    chk("jmp_addr5", imem_addr, 5);
    step();
    chk("jmp_instr", instr, 16'h7123);
    chk("jmp_op", OP, OP_JMP);
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("jmp_tgt", imem_addr, 12'h123);
    chk("jmp_req", imem_req, 1);

    // Jump back to 10 for the branch test
    step();
    chk("jmp2_pc", pc, 12'h123);
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("jmp2_tgt", imem_addr, 10);

    // BEQ -2 taken: 10 + 1 - 2 = 9
    step();
    chk("beq_op", OP, OP_BEQ);
    chk("beq_pc", pc, 10);
    branch = 1'b1;
    step();
    branch = 1'b0;
    chk("beq_taken", imem_addr, 9);

    // Back to 10 again, then not taken
    step();
    chk("ret_pc", pc, 9);
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("ret_tgt", imem_addr, 10);
    step();
    chk("beq2_instr", instr, 16'hD0FE);
    step();
    chk("beq_not_taken", imem_addr, 11);

    // Stall for 3 cycles: instruction held 4 cycles total
    step();
    stall = 1'b1;
    chk("stall_v0", instr_valid, 1);
    chk("stall_pc0", pc, 11);
    step();
    chk("stall_v1", instr_valid, 1);
    chk("stall_i1", instr, 16'h200B);
    step();
    chk("stall_v2", instr_valid, 1);
    chk("stall_p2", pc, 11);
    step();
    stall = 1'b0;
    chk("stall_v3", instr_valid, 1);
    chk("stall_i3", instr, 16'h200B);
    chk("stall_req", imem_req, 0);
    ack_en = 1'b0;
    step();
    chk("stall_exit_valid", instr_valid, 0);

    // Ack delayed 3 cycles: req high 4 cycles, address stable
    for (int k = 0; k < 4; k++) begin
      chk("dly_req", imem_req, 1);
      chk("dly_addr", imem_addr, 12);
      chk("dly_valid", instr_valid, 0);
      if (k == 3) ack_en = 1'b1;
      step();
    end
    chk("dly_issue_valid", instr_valid, 1);
    chk("dly_instr", instr, 16'h7FFF);

    // Jump to 0xFFF, then sequential wraps to 0
    jump = 1'b1;
    step();
    jump = 1'b0;
    chk("wrap_fff", imem_addr, 12'hFFF);
    step();
    chk("wrap_instr", instr, 16'h2FFF);
    step();
    chk("wrap_zero", imem_addr, 0);

    // HALT at address 0
    mem[0] = {OP_HALT, 12'h000};
    step();
    chk("halt_op", OP, OP_HALT);
    chk("halt_valid", instr_valid, 1);
    step();
    chk("halt_flag", halted, 1);
    for (int k = 0; k < 20; k++) begin
      chk("halt_req_lo", imem_req, 0);
      chk("halt_valid_lo", instr_valid, 0);
      step();
    end

    // Reset while a request is outstanding; stray ack afterwards ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    ack_en = 1'b0;
    step();
    chk("mid_req_pending", imem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_req", imem_req, 0);
    chk("mid_pc", pc, 0);
    chk("mid_valid", instr_valid, 0);
    chk("mid_halted", halted, 0);
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    chk("late_ack_instr", instr, 0);
    chk("late_ack_valid", instr_valid, 0);
    chk("late_ack_req", imem_req, 1);
    ack_en = 1'b1;
    step();
    chk("refetch_valid", instr_valid, 1);
    chk("refetch_instr", instr, 16'hF000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit CPU, directly upstream of `ctrlunit`. It holds the PC and fetches one instruction per request/acknowledge handshake from instruction memory. It latches the instruction into an instruction register and presents `OP` to `ctrlunit`. It then consumes `ctrlunit`'s `jump`/`branch` decisions to select the next PC.

## Interface
Parameters:
- `PC_W`, 12: PC / instruction-memory word-address width.
- `INSTR_W`, 16: instruction width. Fixed at 16; the field layout below depends on it.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (ports `clk`, `rst`).
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  PC_W: word address of the fetch; equals `pc`.
- `imem_ack`  in  1: memory has `imem_data` valid this cycle.
- `imem_data`  in  16: fetched instruction.
- `stall`  in  1: downstream cannot accept the issued instruction; hold.
- `jump`  in  1: from `ctrlunit`.
- `branch`  in  1: from `ctrlunit`.
- `OP`  out  4: `instr[15:12]`, to `ctrlunit`.
- `instr`  out  16: instruction register.
- `pc`  out  PC_W: address of the instruction in `instr` while `instr_valid`.
- `instr_valid`  out  1: `instr`/`OP` are a live instruction. Downstream write enables must be gated with it.
- `halted`  out  1: a HALT opcode was issued.

## Operation
- Field layout:
  - `OP` = `instr[15:12]`.
  - Jump target = `instr[11:0]`, zero-extended or truncated to PC_W.
  - Branch offset = `instr[7:0]`, sign-extended to PC_W.
- FSM states: REQ, ISSUE, HALT.
- REQ:
  - Drive `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_req` stays high until `imem_ack` is seen.
  - On `imem_ack`, `instr` <= `imem_data` and the FSM goes to ISSUE.
  - `imem_ack` arriving while `imem_req`=0 is ignored.
- ISSUE:
  - `instr_valid`=1. `jump`/`branch` are sampled this cycle.
  - If `stall`=1: hold state, `pc` and `instr` unchanged; `jump`/`branch` are re-sampled each cycle.
  - If `stall`=0 and `OP`=4'b1111: go to HALT and set `halted`=1.
  - If `stall`=0 otherwise, go to REQ with the next PC:
    - `jump`=1: next PC = jump target.
    - else `branch`=1: next PC = `pc` + 1 + sext(offset).
    - else: next PC = `pc` + 1.
  - `jump` takes priority over `branch` if both are asserted.
- HALT: `imem_req`=0, `instr_valid`=0. The FSM stays here until `rst`.
- PC arithmetic is modulo 2^PC_W: `pc` = all ones + 1 wraps to 0. Branch targets wrap the same way in both directions.
- Reset values: state REQ, `pc`=0, `instr`=0, `imem_req`=0, `instr_valid`=0, `halted`=0.
- Reset mid-operation: an outstanding request is abandoned. `imem_req` is low the cycle after `rst`, and an `imem_ack` in that cycle is ignored.

## Timing
- `imem_req` is registered. It rises the first cycle after reset is released.
- Best case, `imem_ack` returns in the same cycle as `imem_req`: REQ 1 cycle plus ISSUE 1 cycle, giving 1 instruction per 2 cycles.
- Memory latency of N cycles adds N cycles in REQ.
- `OP` is valid from the cycle after the capturing `imem_ack` edge. `ctrlunit` is combinational, so `jump`/`branch` settle within that same ISSUE cycle.
- A redirect takes effect on the `imem_addr` of the very next REQ cycle. There are no delay slots and no wrong-path fetches.
- `instr_valid` falls in the cycle after ISSUE completes. It is never high in REQ or HALT.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants: `OP_JMP`=4'b0111, `OP_BEQ`=4'b1101, `OP_BNE`=4'b1110, `OP_HALT`=4'b1111.
  - Field bit positions.
  - FSM state typedef.
- One sub-module, `fetch_pc_next`: purely combinational next-PC selection and adder (inputs `pc`, `instr`, `jump`, `branch`).
- The FSM, PC register and instruction register stay in `fetch_unit`.

## Test plan
- Reset, then memory acks every request immediately with `imem_data`=16'h2000+addr → `imem_addr` sequence 0,1,2,3 on consecutive REQ cycles; `instr_valid` on alternate cycles; `pc` matches each `instr`.
- `instr` 16'h7123 at pc 5 with `jump`=1 → next `imem_addr`=12'h123; no fetch of address 6.
- BEQ 16'hD0FE at pc 10 with `branch`=1 → next `imem_addr`=9 (10+1−2). Same instruction with `branch`=0 → next `imem_addr`=11.
- `stall`=1 for 3 cycles during ISSUE → `instr`, `pc` and `instr_valid`=1 held for 4 cycles total, then fetch resumes. Ack delayed 3 cycles → `imem_req` held high for 4 cycles with constant `imem_addr`.
- `pc`=12'hFFF, non-branch instruction → next `imem_addr`=0. OP 4'b1111 issued → `halted`=1, `imem_req` stays 0 for 20 cycles.
- `rst` asserted while `imem_req`=1 and ack pending → next cycle `imem_req`=0, `pc`=0, `instr_valid`=0; a late `imem_ack` does not load `instr`.
